// File: rtl/menu_ctrl.sv
// rtl/menu_ctrl.sv - push-button front end and mode/song selection FSM for the music player
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   btn_next   in   raw button, asynchronous, active high
//   btn_ok     in   raw button, asynchronous, active high
//   btn_back   in   raw button, asynchronous, active high
//   song_done  in   one-cycle pulse from the player engine at end of song
//   state      out  [2:0] mode code (free/auto/stdy/play/set)
//   song       out  [2:0] selected song index
//   phase      out  [1:0] 0 BROWSE, 1 SONG, 2 ACTIVE
//   active     out  high while phase is ACTIVE
//   start      out  one-cycle strobe on entry to ACTIVE
//   stop       out  one-cycle strobe on exit from ACTIVE
module menu_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int NUM_SONGS       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_ok,
  input  logic       btn_back,
  input  logic       song_done,
  output logic [2:0] state,
  output logic [2:0] song,
  output logic [1:0] phase,
  output logic       active,
  output logic       start,
  output logic       stop
);

  localparam logic [2:0] FREE_MODE = 3'd0;
  localparam logic [2:0] AUTO_MODE = 3'd1;
  localparam logic [2:0] STDY_MODE = 3'd2;
  localparam logic [2:0] PLAY_MODE = 3'd3;
  localparam logic [2:0] SET_MODE  = 3'd4;

  localparam int         CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] SONG_LAST = 3'(NUM_SONGS - 1);

  // Button index within the packed vectors below.
  localparam int B_NEXT = 0;
  localparam int B_OK   = 1;
  localparam int B_BACK = 2;

  typedef enum logic [1:0] {
    PH_BROWSE = 2'd0,
    PH_SONG   = 2'd1,
    PH_ACTIVE = 2'd2
  } phase_t;

  logic [2:0]    raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    deb_q;
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    press_q;
  logic          done_q;

  phase_t        phase_q;
  logic [2:0]    state_q;
  logic [2:0]    song_q;
  logic          active_q;
  logic          start_q;
  logic          stop_q;

  assign raw = {btn_back, btn_ok, btn_next};

  function automatic logic [2:0] next_mode(input logic [2:0] m);
    case (m)
      FREE_MODE: next_mode = AUTO_MODE;
      AUTO_MODE: next_mode = STDY_MODE;
      STDY_MODE: next_mode = PLAY_MODE;
      PLAY_MODE: next_mode = SET_MODE;
      default:   next_mode = FREE_MODE;
    endcase
  endfunction

  function automatic logic uses_song(input logic [2:0] m);
    uses_song = (m == AUTO_MODE) || (m == STDY_MODE) || (m == PLAY_MODE);
  endfunction

  // Synchroniser + debounce. The press event is registered on the same
  // edge the debounced level rises, so the FSM acts one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      done_q  <= song_done;
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          deb_q[i]   <= sync2_q[i];
          cnt_q[i]   <= '0;
          press_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Mode/song FSM. Event priority is back > ok > next; in ACTIVE, back
  // also wins over song_done so only one stop strobe is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_BROWSE;
      state_q  <= FREE_MODE;
      song_q   <= 3'd0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      case (phase_q)
        PH_BROWSE: begin
          if (press_q[B_BACK]) begin
            phase_q <= PH_BROWSE;
          end else if (press_q[B_OK]) begin
            if (uses_song(state_q)) begin
              phase_q <= PH_SONG;
            end else begin
              phase_q  <= PH_ACTIVE;
              active_q <= 1'b1;
              start_q  <= 1'b1;
            end
          end else if (press_q[B_NEXT]) begin
            state_q <= next_mode(state_q);
          end
        end
        PH_SONG: begin
          if (press_q[B_BACK]) begin
            phase_q <= PH_BROWSE;
          end else if (press_q[B_OK]) begin
            phase_q  <= PH_ACTIVE;
            active_q <= 1'b1;
            start_q  <= 1'b1;
          end else if (press_q[B_NEXT]) begin
            song_q <= (song_q >= SONG_LAST) ? 3'd0 : song_q + 3'd1;
          end
        end
        PH_ACTIVE: begin
          if (press_q[B_BACK]) begin
            phase_q  <= PH_BROWSE;
            active_q <= 1'b0;
            stop_q   <= 1'b1;
          end else if (done_q && uses_song(state_q)) begin
            phase_q  <= PH_SONG;
            active_q <= 1'b0;
            stop_q   <= 1'b1;
          end
        end
        default: begin
          phase_q  <= PH_BROWSE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign state  = state_q;
  assign song   = song_q;
  assign phase  = phase_q;
  assign active = active_q;
  assign start  = start_q;
  assign stop   = stop_q;

endmodule

// File: doc/menu_ctrl.md
# menu_ctrl

User-interface controller for the music-player top level. Takes the raw board push-buttons, synchronises and debounces them, and runs the mode/song selection state machine. Drives the `state` and `song` codes consumed by the seven-segment menu display and the player cores. Also issues single-cycle start/stop strobes to the playback engines.

## Interface

Parameters:

- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive stable samples required before a debounced level changes (20 ms at 100 MHz).
- `NUM_SONGS`, default 2: number of selectable songs, range 1..8.

Ports:

- `clk`  in  1  system clock. One clock domain, no internal derived clocks.
- `rst`  in  1  synchronous, active-high reset.
- `btn_next`  in  1  raw button, asynchronous to `clk`; active high.
- `btn_ok`  in  1  raw button, asynchronous to `clk`; active high.
- `btn_back`  in  1  raw button, asynchronous to `clk`; active high.
- `song_done`  in  1  one-cycle pulse from the player engine when a song finishes.
- `state`  out  3  current mode code, using the Constants.vh macros `free_mode`, `auto_mode`, `stdy_mode`, `play_mode`, `set`.
- `song`  out  3  selected song index. 0 = `little_star`, 1 = `two_tigers`, and so on up to `NUM_SONGS`-1.
- `phase`  out  2  controller phase: 0 BROWSE, 1 SONG, 2 ACTIVE. Encoding 3 is never produced.
- `active`  out  1  high while `phase` is ACTIVE.
- `start`  out  1  one-cycle strobe on entry to ACTIVE.
- `stop`  out  1  one-cycle strobe on exit from ACTIVE.

## Operation

Button front end (one per button):

- Two-flop synchroniser.
- Debounce counter per button. It counts consecutive cycles in which the synchronised level differs from the debounced level. The counter clears whenever the two levels are equal.
- When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips.
- A rising edge of the debounced level produces a one-cycle internal press event.
- A held button produces exactly one event. Glitches shorter than `DEBOUNCE_CYCLES` produce none.

Mode order, used by `next` in BROWSE: `free_mode` → `auto_mode` → `stdy_mode` → `play_mode` → `set` → `free_mode`.

FSM, by phase:

- BROWSE
  - next: advance `state` one step in mode order.
  - ok: if `state` is `free_mode` or `set`, go to ACTIVE. If `state` is `auto_mode`, `stdy_mode` or `play_mode`, go to SONG.
  - back: no effect.
- SONG
  - next: `song` ← `song`+1. After `NUM_SONGS`-1 it wraps to 0.
  - ok: go to ACTIVE.
  - back: go to BROWSE. `song` is retained.
- ACTIVE
  - back: go to BROWSE.
  - `song_done`: go to SONG when `state` is `auto_mode`, `stdy_mode` or `play_mode`. In `free_mode` and `set` it is ignored.
  - next and ok: ignored.

Priority and simultaneous events:

- Simultaneous press events in one cycle are resolved back > ok > next. Only one action is taken.
- `song_done` and back in the same cycle: go to BROWSE, with one `stop` pulse.
- `song_done` outside ACTIVE is ignored.

Strobes and registers:

- `start` is high for exactly the one cycle in which `phase` first reads ACTIVE.
- `stop` is high for exactly the one cycle in which `phase` first reads non-ACTIVE after ACTIVE.
- `state` and `song` never change while in ACTIVE.
- All outputs are registered. No combinational path from any input to any output.

## Timing

- Reset: `state`=`free_mode`, `song`=0, `phase`=BROWSE, `active`=0, `start`=0, `stop`=0.
- Reset also clears the synchronisers, the debounce counters and the debounced levels (to 0).
- Reset asserted while in ACTIVE returns to the reset values with no `stop` pulse.
- A button already held through reset release generates one press event after `DEBOUNCE_CYCLES` + 2 cycles.
- Press latency: the raw button rises and stays stable. Outputs update exactly `DEBOUNCE_CYCLES` + 3 clock edges after the first edge that samples it high. That is 2 synchroniser edges, `DEBOUNCE_CYCLES` counting edges, and 1 FSM edge.
- `song_done` latency: outputs update on the next edge after the one that samples it.
- Press events are edge-only. Holding a button never repeats.

## Test plan

Benches run with `DEBOUNCE_CYCLES`=4 and `NUM_SONGS`=2.

1. Reset, then 5 separate next presses → `state` sequence `auto_mode`, `stdy_mode`, `play_mode`, `set`, `free_mode`. `phase` stays 0. Each change occurs 7 cycles after the raw press.
2. 3-cycle glitch on `btn_ok`, then held 20 cycles → no change after the glitch. Exactly one transition after the hold, no repeat.
3. next, ok (`auto_mode`, SONG), next, next → `song` is 1, then 0 (wrap). Then ok → `phase`=2, `start` high for 1 cycle, `active`=1.
4. In ACTIVE with `auto_mode`, pulse `song_done` → `phase`=1, `stop` high for 1 cycle, `song` unchanged.
5. In ACTIVE, drive `song_done` in the same cycle as the back press event → `phase`=0, exactly one `stop` pulse. Then `rst` mid-ACTIVE → all outputs at reset values, `stop` stays 0.
6. From `free_mode`, press ok → straight to ACTIVE (`start` pulse). Then `song_done` → ignored. Then back → BROWSE with a `stop` pulse.
